// File: rtl/crc16_serial_checker.sv
// -----------------------------------------------------------------------------
// crc16_serial_checker
//
// Receives a serial frame of DATA_BITS payload bits followed by 16 CRC bits,
// MSB first, one bit per din_valid cycle. It computes CRC-16 (poly 0x1021,
// init 0, no reflection, no final XOR) over the payload and keeps running it
// over the appended CRC. A zero residue at the end means the frame is good.
//
// Optional feature: define CRC16_CHK_ERRCNT_EN to add a saturating 8-bit
// error counter output (err_cnt). This counter is cleared only by rst.
//
// Parameters
//   DATA_BITS  payload length in bits (1..63)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   start      frame start request; sampled only in IDLE
//   din_valid  qualifies din; gaps are allowed
//   din        serial frame bit
//   busy       high while payload or CRC bits are being received
//   done       one-cycle pulse after the last CRC bit has been accepted
//   crc_ok     residue-zero result; valid from done until the next start
//   crc_calc   CRC over the payload only, latched at the end of the payload
//   data_out   received payload; the first bit received ends up in the MSB
//   err_cnt    (CRC16_CHK_ERRCNT_EN only) count of bad frames, saturating
// -----------------------------------------------------------------------------
module crc16_serial_checker #(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 din_valid,
    input  logic                 din,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic [15:0]          crc_calc,
    output logic [DATA_BITS-1:0] data_out
`ifdef CRC16_CHK_ERRCNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, DATA, CHK, FIN} state_t;

    localparam logic [5:0] LAST_DATA_IDX = 6'(DATA_BITS - 1);
    localparam logic [5:0] LAST_CRC_IDX  = 6'd15;

    state_t      state, state_nxt;
    logic [15:0] crc_q;
    logic [15:0] crc_upd;
    logic [5:0]  bit_cnt;
    logic        crc_ok_q;
    logic        last_data_bit;
    logic        last_crc_bit;

    // One step of the serial CRC shift register.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_upd       = crc_step(crc_q, din);
    assign last_data_bit = (state == DATA) && din_valid && (bit_cnt == LAST_DATA_IDX);
    assign last_crc_bit  = (state == CHK)  && din_valid && (bit_cnt == LAST_CRC_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every
            // register samples the values from before the edge.
            state <= state_nxt;
        end
    end

    // Next-state and outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first; an incomplete
        // assignment path would otherwise infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        crc_ok    = crc_ok_q;
        case (state)
            IDLE: begin
                if (start) state_nxt = DATA;
            end
            DATA: begin
                busy = 1'b1;
                if (last_data_bit) state_nxt = CHK;
            end
            CHK: begin
                busy = 1'b1;
                if (last_crc_bit) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                // The result is visible in the done cycle itself, then held.
                crc_ok    = (crc_q == 16'h0000);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: running CRC, bit counter, payload shift register, results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q    <= 16'h0000;
            bit_cnt  <= 6'd0;
            data_out <= '0;
            crc_calc <= 16'h0000;
            crc_ok_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // din is deliberately ignored here, even alongside start.
                    if (start) begin
                        crc_q    <= 16'h0000;
                        bit_cnt  <= 6'd0;
                        data_out <= '0;
                        crc_ok_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (din_valid) begin
                        crc_q    <= crc_upd;
                        data_out <= (data_out << 1) | DATA_BITS'(din);
                        if (last_data_bit) begin
                            crc_calc <= crc_upd;
                            bit_cnt  <= 6'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                CHK: begin
                    if (din_valid) begin
                        crc_q <= crc_upd;
                        if (last_crc_bit) bit_cnt <= 6'd0;
                        else              bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                FIN: begin
                    crc_ok_q <= (crc_q == 16'h0000);
                end
                default: ;
            endcase
        end
    end

`ifdef CRC16_CHK_ERRCNT_EN
    // Bad-frame counter; sticks at 8'hFF instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if ((state == FIN) && (crc_q != 16'h0000) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_crc16_serial_checker.sv
// -----------------------------------------------------------------------------
// tb_crc16_serial_checker
//
// Directed bench for crc16_serial_checker with DATA_BITS = 32. Expected CRC
// values are hand-computed for poly 0x1021, init 0:
//   payload 0x00000001 -> 0x1021
//   payload 0x00000003 -> 0x3063
//   payload 0x00000002 -> 0x2042
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge before new inputs are applied.
// -----------------------------------------------------------------------------
module tb_crc16_serial_checker;

    localparam int DB = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          din_valid = 1'b0;
    logic          din = 1'b0;
    logic          busy, done, crc_ok;
    logic [15:0]   crc_calc;
    logic [DB-1:0] data_out;
`ifdef CRC16_CHK_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    int n_total  = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    crc16_serial_checker #(.DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din_valid (din_valid),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_calc  (crc_calc),
        .data_out  (data_out)
`ifdef CRC16_CHK_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Count done pulses; read at the edge, so this sees the pre-edge value.
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Drive frame bits [from..to] of f (bit 0 = f[47]). With gap set, an
    // idle cycle carrying a random din precedes each valid bit. Returns on
    // the falling edge after the edge that accepted bit 'to'.
    task automatic send_bits(input logic [47:0] f, input int from, input int to, input bit gap);
        for (int i = from; i <= to; i++) begin
            if (gap) begin
                din = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            din_valid = 1'b1;
            din       = f[47-i];
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    // One-cycle start pulse; optionally with din_valid=1, din=1 in that cycle.
    task automatic do_start(input bit with_valid);
        start     = 1'b1;
        din_valid = with_valid;
        din       = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_total++; if (done !== 1'b0)        begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_total++; if (crc_ok !== 1'b0)      begin n_bad++; $display("FAIL reset_crc_ok: got %b expected 0", crc_ok); end
        n_total++; if (crc_calc !== 16'h0)   begin n_bad++; $display("FAIL reset_crc_calc: got %h expected 0000", crc_calc); end
        n_total++; if (data_out !== '0)      begin n_bad++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
`ifdef CRC16_CHK_ERRCNT_EN
        n_total++; if (err_cnt !== 8'h00)    begin n_bad++; $display("FAIL reset_err_cnt: got %h expected 00", err_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    // Full frame; checks mid-frame and end-of-frame results.
    task automatic test_frame(input string name, input logic [31:0] payload, input logic [15:0] crc,
                              input bit gap, input logic [15:0] exp_calc, input logic exp_ok);
        logic [47:0] f;
        int d0;
        f  = {payload, crc};
        d0 = done_cnt;
        do_start(1'b0);
        n_total++; if (busy !== 1'b1)        begin n_bad++; $display("FAIL %s start_busy: got %b expected 1", name, busy); end
        send_bits(f, 0, 31, gap);
        n_total++; if (crc_calc !== exp_calc) begin n_bad++; $display("FAIL %s mid_crc_calc: got %h expected %h", name, crc_calc, exp_calc); end
        n_total++; if (data_out !== payload) begin n_bad++; $display("FAIL %s mid_data_out: got %h expected %h", name, data_out, payload); end
        send_bits(f, 32, 46, gap);
        n_total++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL %s before_last: got done=%b busy=%b expected done=0 busy=1", name, done, busy); end
        send_bits(f, 47, 47, gap);
        n_total++; if (done !== 1'b1)        begin n_bad++; $display("FAIL %s done: got %b expected 1", name, done); end
        n_total++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL %s fin_busy: got %b expected 0", name, busy); end
        n_total++; if (crc_ok !== exp_ok)    begin n_bad++; $display("FAIL %s crc_ok: got %b expected %b", name, crc_ok, exp_ok); end
`ifdef CRC16_CHK_ERRCNT_EN
        if (name == "bad_crc") begin
            n_total++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL %s err_cnt_fin: got %h expected 00", name, err_cnt); end
        end
`endif
        @(negedge clk);
        n_total++; if (done !== 1'b0)        begin n_bad++; $display("FAIL %s done_width: got %b expected 0", name, done); end
        n_total++; if (crc_ok !== exp_ok)    begin n_bad++; $display("FAIL %s crc_ok_held: got %b expected %b", name, crc_ok, exp_ok); end
        n_total++; if (crc_calc !== exp_calc) begin n_bad++; $display("FAIL %s crc_calc: got %h expected %h", name, crc_calc, exp_calc); end
        n_total++; if (data_out !== payload) begin n_bad++; $display("FAIL %s data_out: got %h expected %h", name, data_out, payload); end
`ifdef CRC16_CHK_ERRCNT_EN
        if (name == "bad_crc") begin
            n_total++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL %s err_cnt: got %h expected 01", name, err_cnt); end
        end
`endif
        repeat (2) @(negedge clk);
        n_total++; if (done_cnt !== d0 + 1)  begin n_bad++; $display("FAIL %s done_count: got %0d expected %0d", name, done_cnt, d0 + 1); end
    endtask

    task automatic test_bad_crc();
        test_frame("bad_crc", 32'h00000002, 16'h2043, 1'b0, 16'h2042, 1'b0);
    endtask

    task automatic test_continuous();
        test_frame("continuous", 32'h00000001, 16'h1021, 1'b0, 16'h1021, 1'b1);
    endtask

    task automatic test_gapped();
        test_frame("gapped", 32'h00000003, 16'h3063, 1'b1, 16'h3063, 1'b1);
    endtask

    // din_valid together with start must not be taken as a payload bit.
    task automatic test_start_with_valid();
        logic [47:0] f;
        f = {32'h00000001, 16'h1021};
        do_start(1'b1);
        send_bits(f, 0, 47, 1'b0);
        n_total++; if (done !== 1'b1 || crc_ok !== 1'b1) begin n_bad++; $display("FAIL start_valid done_ok: got done=%b ok=%b expected 1 1", done, crc_ok); end
        n_total++; if (data_out !== 32'h00000001) begin n_bad++; $display("FAIL start_valid data_out: got %h expected 00000001", data_out); end
        n_total++; if (crc_calc !== 16'h1021) begin n_bad++; $display("FAIL start_valid crc_calc: got %h expected 1021", crc_calc); end
        @(negedge clk);
    endtask

    // Reset mid-payload discards the frame; a clean frame follows.
    task automatic test_reset_abort();
        logic [47:0] f;
        int d0;
        f  = {32'h00000001, 16'h1021};
        d0 = done_cnt;
        do_start(1'b0);
        send_bits(f, 0, 19, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0 || crc_ok !== 1'b0) begin n_bad++; $display("FAIL abort_async: got busy=%b ok=%b expected 0 0", busy, crc_ok); end
        n_total++; if (data_out !== '0 || crc_calc !== 16'h0) begin n_bad++; $display("FAIL abort_clear: got data=%h calc=%h expected 0 0", data_out, crc_calc); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (done_cnt !== d0)      begin n_bad++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0); end
        do_start(1'b0);
        send_bits(f, 0, 47, 1'b0);
        n_total++; if (done !== 1'b1 || crc_ok !== 1'b1) begin n_bad++; $display("FAIL abort_second: got done=%b ok=%b expected 1 1", done, crc_ok); end
        repeat (2) @(negedge clk);
        n_total++; if (done_cnt !== d0 + 1)  begin n_bad++; $display("FAIL abort_done_count: got %0d expected %0d", done_cnt, d0 + 1); end
    endtask

    // start in DATA, CHK and FIN must be ignored.
    task automatic test_start_ignored();
        logic [47:0] f;
        int d0;
        f  = {32'h00000001, 16'h1021};
        d0 = done_cnt;
        do_start(1'b0);
        send_bits(f, 0, 9, 1'b0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        send_bits(f, 10, 35, 1'b0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        send_bits(f, 36, 47, 1'b0);
        n_total++; if (done !== 1'b1 || crc_ok !== 1'b1) begin n_bad++; $display("FAIL ign done_ok: got done=%b ok=%b expected 1 1", done, crc_ok); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_total++; if (busy !== 1'b0 || crc_ok !== 1'b1) begin n_bad++; $display("FAIL ign fin_start: got busy=%b ok=%b expected 0 1", busy, crc_ok); end
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL ign idle: got busy=%b expected 0", busy); end
        n_total++; if (done_cnt !== d0 + 1)  begin n_bad++; $display("FAIL ign done_count: got %0d expected %0d", done_cnt, d0 + 1); end
        n_total++; if (data_out !== 32'h00000001) begin n_bad++; $display("FAIL ign data_out: got %h expected 00000001", data_out); end
    endtask

`ifdef CRC16_CHK_ERRCNT_EN
    task automatic test_err_saturate();
        logic [47:0] f;
        f = {32'h00000002, 16'h2043};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            do_start(1'b0);
            send_bits(f, 0, 47, 1'b0);
            @(negedge clk);
            if (k == 254) begin
                n_total++; if (err_cnt !== 8'hFE) begin n_bad++; $display("FAIL err_254: got %h expected fe", err_cnt); end
            end
        end
        n_total++; if (err_cnt !== 8'hFF)    begin n_bad++; $display("FAIL err_saturate: got %h expected ff", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_bad_crc();
        test_continuous();
        test_gapped();
        test_start_with_valid();
        test_reset_abort();
        test_start_ignored();
`ifdef CRC16_CHK_ERRCNT_EN
        test_err_saturate();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

endmodule
